// File: rtl/and_gate_tester.sv
// Exhaustive tester for a 2-input AND gate: drives all four input vectors,
// waits a programmable settle time, and records which vectors gave a wrong response.
module and_gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRIVE  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic       SKIP_SETTLE = (SETTLE_CYCLES == 0);
  localparam logic [2:0] ERR_MAX     = 3'd4;

  logic [2:0] state;
  logic [1:0] idx;
  logic [3:0] settle_cnt;
  logic       mismatch;

  assign busy     = (state != IDLE);
  assign mismatch = (y_in != (a_out & b_out));

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 2'd0;
      settle_cnt <= 4'd0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_vec   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          if (start) begin
            state     <= DRIVE;
            idx       <= 2'd0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
          end
        end
        DRIVE: begin
          a_out <= idx[1];
          b_out <= idx[0];
          if (SKIP_SETTLE) begin
            state <= CHECK;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // Leaving on a count of 1 gives exactly SETTLE_CYCLES cycles here.
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt <= 4'd1) state <= CHECK;
        end
        CHECK: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            if (err_count != ERR_MAX) err_count <= err_count + 3'd1;
          end
          if (idx == 2'd3) begin
            state <= DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == 3'd0);
          a_out <= 1'b0;
          b_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_tester.sv
// Scoreboard bench for and_gate_tester: two instances (settle 2 and settle 0)
// driven by directed runs against several models of the gate under test.
module tb_and_gate_tester;

  localparam int LAT0 = 17;  // 4*(2+2)+1
  localparam int LAT1 = 9;   // 4*(0+2)+1

  localparam int M_AND = 0, M_ST0 = 1, M_ST1 = 2, M_OR = 3;

  typedef struct {
    int unsigned start_edge;
    logic        pass;
    logic [2:0]  err;
    logic [3:0]  fv;
  } exp_t;

  logic       clk = 1'b0;
  logic [1:0] rst_n, start, y_in, a_out, b_out, busy, done, pass;
  logic [2:0] err_count [2];
  logic [3:0] fail_vec  [2];
  int         mode [2];

  int unsigned cycle = 0;
  int          n_pass = 0;
  int          n_total = 0;

  exp_t sbq0[$];
  exp_t sbq1[$];

  logic [15:0] seq [2];
  int          seq_len [2];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic gate_model(int md, logic a, logic b);
    case (md)
      M_ST0:   return 1'b0;
      M_ST1:   return 1'b1;
      M_OR:    return a | b;
      default: return a & b;
    endcase
  endfunction

  always_comb begin
    y_in[0] = gate_model(mode[0], a_out[0], b_out[0]);
    y_in[1] = gate_model(mode[1], a_out[1], b_out[1]);
  end

  and_gate_tester #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .y_in(y_in[0]),
    .a_out(a_out[0]), .b_out(b_out[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .err_count(err_count[0]), .fail_vec(fail_vec[0])
  );

  and_gate_tester #(.SETTLE_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .y_in(y_in[1]),
    .a_out(a_out[1]), .b_out(b_out[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .err_count(err_count[1]), .fail_vec(fail_vec[1])
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
  endtask

  function automatic int qsize(int k);
    return (k == 0) ? sbq0.size() : sbq1.size();
  endfunction

  // Monitor: pops the scoreboard on every done pulse and tracks the vector sequence.
  task automatic monitor_step(int k);
    exp_t        e;
    int unsigned lat;
    if (busy[k]) begin
      if (seq_len[k] == 0 || {a_out[k], b_out[k]} != seq[k][1:0]) begin
        seq[k] = {seq[k][13:0], a_out[k], b_out[k]};
        seq_len[k]++;
      end
    end
    if (done[k]) begin
      if (qsize(k) == 0) begin
        check($sformatf("unexpected_done%0d", k), 1, 0);
      end else begin
        e   = (k == 0) ? sbq0.pop_front() : sbq1.pop_front();
        lat = (k == 0) ? LAT0 : LAT1;
        check($sformatf("latency%0d", k), cycle - e.start_edge, lat);
        check($sformatf("pass%0d", k), pass[k], e.pass);
        check($sformatf("err_count%0d", k), err_count[k], e.err);
        check($sformatf("fail_vec%0d", k), fail_vec[k], e.fv);
        check($sformatf("vec_seq%0d", k), {seq_len[k], seq[k]}, {32'd4, 16'h001b} >> 0);
      end
      seq[k] = '0;
      seq_len[k] = 0;
    end
    if (!rst_n[k]) begin
      seq[k] = '0;
      seq_len[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    monitor_step(0);
    monitor_step(1);
  end

  task automatic push(int k, int unsigned se, logic p, logic [2:0] e, logic [3:0] f);
    exp_t x;
    x.start_edge = se;
    x.pass = p;
    x.err = e;
    x.fv = f;
    if (k == 0) sbq0.push_back(x);
    else sbq1.push_back(x);
  endtask

  // Returns #1 after the accepting edge, with start already dropped.
  task automatic issue(int k, int md, logic p, logic [2:0] e, logic [3:0] f,
                       output int unsigned se);
    @(posedge clk); #1;
    mode[k]  = md;
    start[k] = 1'b1;
    se = cycle + 1;
    push(k, se, p, e, f);
    @(posedge clk); #1;
    start[k] = 1'b0;
  endtask

  task automatic drain(int k);
    for (int i = 0; i < 200 && qsize(k) != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check($sformatf("drain%0d", k), qsize(k), 0);
  endtask

  initial begin
    int unsigned se;
    rst_n = 2'b00;
    start = 2'b00;
    mode[0] = M_AND;
    mode[1] = M_AND;
    seq[0] = '0; seq[1] = '0;
    seq_len[0] = 0; seq_len[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("reset_state%0d", k),
            {a_out[k], b_out[k], busy[k], done[k], pass[k], err_count[k], fail_vec[k]}, 0);
    rst_n = 2'b11;

    // Settle 2: each gate model
    issue(0, M_AND, 1'b1, 3'd0, 4'b0000, se);
    drain(0);
    issue(0, M_ST0, 1'b0, 3'd1, 4'b1000, se);
    drain(0);
    issue(0, M_ST1, 1'b0, 3'd3, 4'b0111, se);
    drain(0);
    issue(0, M_OR, 1'b0, 3'd2, 4'b0110, se);
    check("clear_on_accept_fv0", fail_vec[0], 4'b0000);
    check("clear_on_accept_err0", err_count[0], 3'd0);
    drain(0);

    // Start pulsed mid-run is ignored
    issue(0, M_AND, 1'b1, 3'd0, 4'b0000, se);
    repeat (4) @(posedge clk);
    #1 start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    drain(0);

    // Start held across DONE launches a second run one cycle after done
    @(posedge clk); #1;
    mode[0]  = M_AND;
    start[0] = 1'b1;
    se = cycle + 1;
    push(0, se, 1'b1, 3'd0, 4'b0000);
    push(0, se + 18, 1'b1, 3'd0, 4'b0000);
    while (cycle < se + 18) @(posedge clk);
    #1 start[0] = 1'b0;
    drain(0);

    // Reset during vector 2 settle aborts the run
    issue(0, M_ST0, 1'b0, 3'd1, 4'b1000, se);
    while (cycle < se + 9) @(posedge clk);
    #1;
    check("mid_run_busy", busy[0], 1'b1);
    rst_n[0] = 1'b0;
    void'(sbq0.pop_back());
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    check("abort_outputs",
          {a_out[0], b_out[0], busy[0], done[0], pass[0], err_count[0], fail_vec[0]}, 0);
    repeat (25) @(posedge clk);
    issue(0, M_AND, 1'b1, 3'd0, 4'b0000, se);
    drain(0);

    // Reset wins over start on the same edge
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    start[0] = 1'b0;
    check("reset_priority", {busy[0], pass[0]}, 2'b00);
    repeat (20) @(posedge clk);

    // Settle 0
    issue(1, M_AND, 1'b1, 3'd0, 4'b0000, se);
    drain(1);
    issue(1, M_ST0, 1'b0, 3'd1, 4'b1000, se);
    check("clear_on_accept_pass1", pass[1], 1'b0);
    drain(1);
    issue(1, M_AND, 1'b1, 3'd0, 4'b0000, se);
    check("clear_on_accept_fv1", fail_vec[1], 4'b0000);
    check("clear_on_accept_err1", err_count[1], 3'd0);
    drain(1);

    repeat (5) @(posedge clk);
    #1;
    check("final_queues", sbq0.size() + sbq1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/and_gate_tester.md
AND_GATE_TESTER -- requirements
Module: and_gate_tester

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, meaning cycles to wait after driving a vector before sampling y_in; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 y_in  input  1  response from the 2-input AND under test.
REQ-006 a_out  output  1  stimulus A to the device under test, registered.
REQ-007 b_out  output  1  stimulus B to the device under test, registered.
REQ-008 busy  output  1  high while a run is in progress (any state other than IDLE).
REQ-009 done  output  1  one-cycle pulse at run completion.
REQ-010 pass  output  1  high when the last completed run had zero mismatches; held until the next accepted start.
REQ-011 err_count  output  3  mismatch count of the current or last run, 0..4.
REQ-012 fail_vec  output  4  bit i set when vector i mismatched; vector i drives {a_out,b_out} = {i[1],i[0]}.

Function
REQ-013 FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE; 2-bit vector index idx; settle counter of at least 4 bits.
REQ-014 IDLE: a_out=b_out=0 and busy=0; start=1 -> DRIVE with idx=0, and pass, err_count and fail_vec cleared in the same edge.
REQ-015 DRIVE (1 cycle): a_out<=idx[1] and b_out<=idx[0]; next state SETTLE with counter loaded to SETTLE_CYCLES, or CHECK if SETTLE_CYCLES=0.
REQ-016 SETTLE: counter decrements each cycle; the state exits to CHECK on the cycle the counter reaches 1, so exactly SETTLE_CYCLES cycles are spent in SETTLE.
REQ-017 CHECK (1 cycle): expected = a_out & b_out; if y_in != expected, then fail_vec[idx]<=1 and err_count<=err_count+1.
REQ-018 CHECK exit: if idx==3 -> DONE; otherwise idx<=idx+1 and -> DRIVE.
REQ-019 DONE (1 cycle): done=1 and pass<=(err_count==0 including the final CHECK result); then -> IDLE, with a_out=b_out=0.
REQ-020 Latency: each vector takes SETTLE_CYCLES+2 cycles; done asserts 4*(SETTLE_CYCLES+2)+1 cycles after the edge that accepted start.
REQ-021 start while busy is ignored, with no restart and no effect on results; start held high in IDLE right after DONE starts a new run.
REQ-022 a_out and b_out hold stable throughout SETTLE and CHECK of each vector.
REQ-023 err_count never wraps; its maximum is 4.
REQ-024 y_in is used only in CHECK; its value in all other states is ignored.

Reset
REQ-025 rst_n=0 at a clock edge forces: state IDLE, idx=0, a_out=b_out=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-026 Reset mid-run aborts the run with no done pulse; partial results are discarded.
REQ-027 Reset has priority over start when both are asserted at the same edge.

Verification
REQ-028 Correct AND model on y_in, SETTLE_CYCLES=2 -> a_out,b_out step 00,01,10,11; done at cycle 17 after start; pass=1, err_count=0, fail_vec=4'b0000.
REQ-029 y_in stuck at 0 -> fail_vec=4'b1000, err_count=1, pass=0.
REQ-030 y_in stuck at 1 -> fail_vec=4'b0111, err_count=3, pass=0; y_in = a|b (OR model) -> fail_vec=4'b0110, err_count=2.
REQ-031 start pulsed again at cycle 5 of a run -> ignored; single done at cycle 17; results identical to REQ-028.
REQ-032 rst_n low for one edge during vector 2 SETTLE -> all outputs zero next cycle, no done; a new start gives a clean run.
REQ-033 SETTLE_CYCLES=0 with correct model -> done at cycle 9 after start, pass=1; a following run's start clears the previous pass/fail_vec on acceptance.
